// File: rtl/fork_scheduler.sv
// fork_scheduler: grants both forks of a ring philosopher atomically, several per cycle, round-robin.
// Define FORK_AGING_EN to add a two-pass scan that favours waiters aged to AGE_MAX.
module fork_scheduler #(
   parameter int N       = 16,
   parameter int AGE_MAX = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic [N-1:0] rel,
   output logic [N-1:0] grant,
   output logic [N-1:0] fork_busy,
   output logic [N-1:0] starving
);
   localparam int PW = $clog2(N);
   typedef enum logic [1:0] {IDLE, WAIT, EAT} state_t;
   state_t        st    [N];
   state_t        st_nx [N];
   logic [PW-1:0] ptr, ptr_nx;
   logic [N-1:0]  cand, sel, grant_nx;

   if (N < 3 || AGE_MAX < 1) begin : g_param_check
      $error("fork_scheduler: N must be >= 3 and AGE_MAX >= 1");
   end

   // Fork k is shared by philosophers k and k-1.
   function automatic logic [N-1:0] forks_of(input logic [N-1:0] p);
      return p | {p[N-2:0], p[N-1]};
   endfunction

   function automatic logic [N-1:0] scan(input logic [PW-1:0] p, input logic [N-1:0] c,
                                         input logic [N-1:0] taken);
      logic [N-1:0] t, s;
      int i, j;
      t = taken;
      s = '0;
      for (int k = 0; k < N; k++) begin
         i = (int'(p) + k) % N;
         j = (i + 1) % N;
         if (c[i] && !t[i] && !t[j]) begin
            s[i] = 1'b1;
            t[i] = 1'b1;
            t[j] = 1'b1;
         end
      end
      return s;
   endfunction

   always_comb begin
      for (int i = 0; i < N; i++) cand[i] = (st[i] == WAIT) && req[i];
   end

`ifdef FORK_AGING_EN
   localparam int CW = $clog2(AGE_MAX + 1);
   logic [CW-1:0] age    [N];
   logic [CW-1:0] age_nx [N];
   logic [N-1:0]  sel_starving;

   always_comb begin
      sel_starving = scan(ptr, cand & starving, fork_busy);
      // Starving waiters that missed out keep their forks out of the normal pass.
      sel = sel_starving | scan(ptr, cand & ~starving,
                                fork_busy | forks_of(sel_starving) | forks_of(starving & ~sel_starving));
      for (int i = 0; i < N; i++)
         age_nx[i] = (cand[i] && !sel[i]) ? ((age[i] == CW'(AGE_MAX)) ? age[i] : age[i] + 1'b1) : '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++) age[i] <= '0;
         starving <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            age[i]      <= age_nx[i];
            starving[i] <= (age_nx[i] == CW'(AGE_MAX));
         end
      end
   end
`else
   assign starving = '0;
   assign sel      = scan(ptr, cand, fork_busy);
`endif

   always_comb begin
      ptr_nx = ptr;
      for (int k = N - 1; k >= 0; k--) begin
         if (sel[(int'(ptr) + k) % N]) ptr_nx = PW'((int'(ptr) + k + 1) % N);
      end
      for (int i = 0; i < N; i++) begin
         st_nx[i] = (st[i] == IDLE) ? (req[i] ? WAIT : IDLE) :
                    (st[i] == WAIT) ? (!req[i] ? IDLE : sel[i] ? EAT : WAIT) :
                    (rel[i] ? IDLE : EAT);
         grant_nx[i] = (st_nx[i] == EAT);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++) st[i] <= IDLE;
         ptr       <= '0;
         grant     <= '0;
         fork_busy <= '0;
      end else begin
         st        <= st_nx;
         ptr       <= ptr_nx;
         grant     <= grant_nx;
         fork_busy <= forks_of(grant_nx);
      end
   end
endmodule

// File: tb/tb_fork_scheduler.sv
// tb_fork_scheduler: directed and random stimulus checked each cycle against a fork-ownership model.
module tb_fork_scheduler;
   localparam int N       = 16;
   localparam int AGE_MAX = 4;
`ifdef FORK_AGING_EN
   localparam bit AGING = 1'b1;
`else
   localparam bit AGING = 1'b0;
`endif

   logic         clock   = 1'b0;
   logic         reset_n = 1'b1;
   logic [N-1:0] req = '0, rel = '0;
   logic [N-1:0] grant, fork_busy, starving;
   int checks = 0, errors = 0;
   int m_st  [N];
   int m_age [N];
   int m_ptr;
   bit ever1;

   fork_scheduler #(.N(N), .AGE_MAX(AGE_MAX)) dut (
      .clock(clock), .reset_n(reset_n), .req(req), .rel(rel),
      .grant(grant), .fork_busy(fork_busy), .starving(starving));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Model states: 0 idle, 1 waiting, 2 eating.
   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i]  = 0;
         m_age[i] = 0;
      end
      m_ptr = 0;
   endtask

   task automatic model_step();
      bit used [N];
      bit want [N];
      bit starv [N];
      bit pick [N];
      bit found;
      int i, j;
      for (int k = 0; k < N; k++) begin
         used[k]  = (m_st[k] == 2) || (m_st[(k + N - 1) % N] == 2);
         want[k]  = (m_st[k] == 1) && req[k];
         starv[k] = AGING && (m_age[k] == AGE_MAX);
         pick[k]  = 1'b0;
      end
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            j = (i + 1) % N;
            if (want[i] && (starv[i] == (pass == 0)) && !used[i] && !used[j]) begin
               pick[i] = 1'b1;
               used[i] = 1'b1;
               used[j] = 1'b1;
            end
         end
         if (pass == 0) begin
            for (int k = 0; k < N; k++)
               if (starv[k] && !pick[k]) begin
                  used[k] = 1'b1;
                  used[(k + 1) % N] = 1'b1;
               end
         end
      end
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         i = (m_ptr + k) % N;
         if (!found && pick[i]) begin
            found = 1'b1;
            m_ptr = (i + 1) % N;
         end
      end
      for (int k = 0; k < N; k++) begin
         m_age[k] = (want[k] && !pick[k]) ? ((m_age[k] < AGE_MAX) ? m_age[k] + 1 : AGE_MAX) : 0;
         case (m_st[k])
            0:       m_st[k] = req[k] ? 1 : 0;
            1:       m_st[k] = !req[k] ? 0 : (pick[k] ? 2 : 1);
            default: m_st[k] = rel[k] ? 0 : 2;
         endcase
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] g, b, s, adj;
      for (int k = 0; k < N; k++) begin
         g[k]   = (m_st[k] == 2);
         b[k]   = (m_st[k] == 2) || (m_st[(k + N - 1) % N] == 2);
         s[k]   = AGING && (m_age[k] == AGE_MAX);
         adj[k] = grant[k] & grant[(k + 1) % N];
      end
      chk({tag, " grant"}, grant, g);
      chk({tag, " fork_busy"}, fork_busy, b);
      chk({tag, " starving"}, starving, s);
      chk({tag, " adjacent"}, adj, '0);
   endtask

   task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input string tag);
      req = r;
      rel = l;
      model_step();
      @(posedge clock);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      req = '0;
      rel = '0;
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      @(posedge clock);
      #3 reset_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] r, l;
      #1 reset_n = 1'b0;
      model_reset();
      #1 check_all("por");
      #10 reset_n = 1'b1;
      @(posedge clock);
      #1;
      cycle('0, '0, "idle");
      cycle('0, '0, "idle");

      cycle(16'h0005, '0, "rst_setup");
      cycle(16'h0005, '0, "rst_setup");
      chk("rst_setup_grant", grant, 16'h0005);
      do_reset();
      chk("rst_mid_meal_grant", grant, '0);
      cycle('0, '0, "after_rst");
      cycle('0, '0, "after_rst");

      cycle(16'h0008, '0, "single_wait");
      chk("single_not_yet", grant, '0);
      cycle(16'h0008, '0, "single_grant");
      chk("single_grant", grant, 16'h0008);
      chk("single_busy", fork_busy, 16'h0018);
      cycle(16'h0008, 16'h0008, "single_rel");
      chk("single_rel_busy", fork_busy, '0);
      cycle('0, '0, "single_idle");

      do_reset();
      cycle(16'h0018, '0, "nb_wait");
      cycle(16'h0018, '0, "nb_grant");
      chk("nb_only3", grant, 16'h0008);
      cycle(16'h0010, 16'h0008, "nb_rel3");
      chk("nb_fork_not_free_yet", grant, '0);
      cycle(16'h0010, '0, "nb_grant4");
      chk("nb_grant4", grant, 16'h0010);
      cycle('0, 16'h0010, "nb_rel4");

      do_reset();
      cycle(16'hFFFF, '0, "full_wait");
      cycle(16'hFFFF, '0, "full_grant");
      chk("full_grant", grant, 16'h5555);
      chk("full_busy", fork_busy, 16'hFFFF);
      cycle(16'hFFFF, 16'h5555, "full_rel");
      cycle(16'hFFFF, '0, "full_odd");
      chk("full_odd", grant, 16'hAAAA);
      cycle('0, 16'hFFFF, "full_done");
      cycle('0, '0, "full_idle");

      do_reset();
      cycle(16'h0050, '0, "wd_setup");
      cycle(16'h0050, '0, "wd_setup");
      chk("wd_holders", grant, 16'h0050);
      cycle(16'h0070, '0, "wd_req5");
      cycle(16'h0050, '0, "wd_withdraw");
      cycle('0, 16'h0050, "wd_release");
      for (int c = 0; c < 4; c++) begin
         cycle('0, '0, "wd_after");
         chk("wd_no_grant5", grant & 16'h0020, '0);
      end

      do_reset();
      ever1 = 1'b0;
      for (int c = 0; c < 200; c++) begin
         l = (c % 4 == 0) ? 16'h0001 : (c % 4 == 2) ? 16'h0004 : 16'h0000;
         cycle(16'h0007, l, "aging");
         if (grant[1]) ever1 = 1'b1;
      end
      checks++;
      assert (ever1 === AGING) else begin
         errors++;
         $error("FAIL aging_grant1 got %0b expected %0b", ever1, AGING);
      end

      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (c % 100 == 99) do_reset();
         r = 16'($urandom | $urandom);
         l = 16'($urandom & $urandom);
         cycle(r, l, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
